// File: rtl/misc_pkg.sv
// Shared definitions for the misc register window: widths, register offsets,
// the exported register snapshot and the byte-merge helper.
package misc_pkg;

    localparam int MISC_ADDR_WIDTH  = 12;
    localparam int MISC_DATA_WIDTH  = 64;
    localparam int MISC_WMASK_WIDTH = 8;

    localparam logic [MISC_ADDR_WIDTH-1:0] MTIME_REG_OFFSET    = 12'h000;
    localparam logic [MISC_ADDR_WIDTH-1:0] MTIMECMP_REG_OFFSET = 12'h008;
    localparam logic [MISC_ADDR_WIDTH-1:0] DISPLAY_REG_OFFSET  = 12'h010;

    typedef enum logic {
        MISC_IDLE,
        MISC_RESP
    } MiscState;

    typedef struct packed {
        logic [MISC_DATA_WIDTH-1:0] misc_mtime;
        logic [MISC_DATA_WIDTH-1:0] misc_mtimecmp;
        logic [MISC_DATA_WIDTH-1:0] misc_display;
    } MiscInfo;

    // Byte i of the result comes from new_value when mask[i] is set, else from old_value.
    function automatic logic [MISC_DATA_WIDTH-1:0] misc_merge(
        input logic [MISC_DATA_WIDTH-1:0]  old_value,
        input logic [MISC_DATA_WIDTH-1:0]  new_value,
        input logic [MISC_WMASK_WIDTH-1:0] mask
    );
        logic [MISC_DATA_WIDTH-1:0] merged;
        merged = old_value;
        for (int i = 0; i < MISC_WMASK_WIDTH; i++) begin
            if (mask[i]) begin
                merged[i*8 +: 8] = new_value[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/misc_timer.sv
// Free-running mtime counter with a prescaler; a load overrides the increment
// in the same cycle while the prescaler keeps counting.
module misc_timer
    import misc_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       tick_en,
    input  logic                       load,
    input  logic [MISC_DATA_WIDTH-1:0] load_value,
    output logic [MISC_DATA_WIDTH-1:0] mtime,
    output logic                       tick
);

    localparam logic [31:0] PRESCALE_LAST = 32'(TICK_DIV - 1);

    logic [31:0]                prescale_reg;
    logic [MISC_DATA_WIDTH-1:0] mtime_reg;

    assign tick  = tick_en && (prescale_reg == PRESCALE_LAST);
    assign mtime = mtime_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prescale_reg <= '0;
            mtime_reg    <= '0;
        end else begin
            if (tick_en) begin
                prescale_reg <= tick ? 32'd0 : prescale_reg + 32'd1;
            end
            if (load) begin
                mtime_reg <= load_value;
            end else if (tick) begin
                mtime_reg <= mtime_reg + 64'd1;
            end
        end
    end

endmodule

// File: rtl/misc_ctrl.sv
// Bus slave for the misc window: request/response FSM, register decode,
// mtimecmp/display storage and the registered machine timer interrupt.
module misc_ctrl
    import misc_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [MISC_ADDR_WIDTH-1:0]  req_addr,
    input  logic [MISC_DATA_WIDTH-1:0]  req_wdata,
    input  logic [MISC_WMASK_WIDTH-1:0] req_wmask,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [MISC_DATA_WIDTH-1:0]  resp_rdata,
    output logic                        mtip,
    output logic                        display_we,
    output MiscInfo                     misc_info
);

    MiscState                   state_reg, state_next;
    logic [MISC_DATA_WIDTH-1:0] mtime;
    logic [MISC_DATA_WIDTH-1:0] mtimecmp_reg;
    logic [MISC_DATA_WIDTH-1:0] display_reg;
    logic [MISC_DATA_WIDTH-1:0] rdata_reg;
    logic                       mtip_reg;
    logic                       display_we_reg;
    logic                       timer_tick;

    logic [MISC_ADDR_WIDTH-4:0] reg_index;
    logic                       sel_mtime, sel_mtimecmp, sel_display;
    logic                       accept;
    logic                       mtime_load;
    logic [MISC_DATA_WIDTH-1:0] read_value;

    // Byte-lane bits of the address and the tick strobe carry no meaning here.
    logic unused_ok;
    assign unused_ok = &{1'b0, req_addr[2:0], timer_tick};

    assign reg_index    = req_addr[MISC_ADDR_WIDTH-1:3];
    assign sel_mtime    = (reg_index == MTIME_REG_OFFSET[MISC_ADDR_WIDTH-1:3]);
    assign sel_mtimecmp = (reg_index == MTIMECMP_REG_OFFSET[MISC_ADDR_WIDTH-1:3]);
    assign sel_display  = (reg_index == DISPLAY_REG_OFFSET[MISC_ADDR_WIDTH-1:3]);

    assign accept = req_ready && req_valid;
    // An all-zero mask must not suppress the timer increment.
    assign mtime_load = accept && req_we && sel_mtime && (|req_wmask);

    always_comb begin
        read_value = '0;
        if (sel_mtime) begin
            read_value = mtime;
        end else if (sel_mtimecmp) begin
            read_value = mtimecmp_reg;
        end else if (sel_display) begin
            read_value = display_reg;
        end
    end

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_reg)
            MISC_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = MISC_RESP;
                end
            end
            MISC_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = MISC_IDLE;
                end
            end
            default: state_next = MISC_IDLE;
        endcase
    end

    misc_timer #(
        .TICK_DIV(TICK_DIV)
    ) u_timer (
        .clk       (clk),
        .rstn      (rstn),
        .tick_en   (1'b1),
        .load      (mtime_load),
        .load_value(misc_merge(mtime, req_wdata, req_wmask)),
        .mtime     (mtime),
        .tick      (timer_tick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= MISC_IDLE;
            mtimecmp_reg   <= '1;
            display_reg    <= '0;
            rdata_reg      <= '0;
            mtip_reg       <= 1'b0;
            display_we_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            mtip_reg       <= (mtime >= mtimecmp_reg);
            display_we_reg <= accept && req_we && sel_display;
            if (accept) begin
                rdata_reg <= req_we ? '0 : read_value;
                if (req_we && sel_mtimecmp) begin
                    mtimecmp_reg <= misc_merge(mtimecmp_reg, req_wdata, req_wmask);
                end
                if (req_we && sel_display) begin
                    display_reg <= misc_merge(display_reg, req_wdata, req_wmask);
                end
            end
        end
    end

    assign resp_rdata = rdata_reg;
    assign mtip       = mtip_reg;
    assign display_we = display_we_reg;
    assign misc_info  = '{misc_mtime: mtime, misc_mtimecmp: mtimecmp_reg, misc_display: display_reg};

endmodule

// File: tb/tb_misc_ctrl.sv
// Directed bench for misc_ctrl: a table of single transactions plus hand-written
// sequences for timer interrupt latency, mtime write/tick collision, stalls and reset.
module tb_misc_ctrl;
    import misc_pkg::*;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [11:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        mtip;
    logic        display_we;
    MiscInfo     misc_info;

    int passed;
    int total;

    misc_ctrl #(.TICK_DIV(1)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .mtip      (mtip),
        .display_we(display_we),
        .misc_info (misc_info)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Snapshots: s0 = cycle of presentation, s1 = first RESP cycle, s2 = cycle after.
    logic        s0_ready, s1_valid, s1_dwe, s1_mtip, s2_ready, s2_valid, s2_dwe, s2_mtip;
    logic [63:0] s0_mtime, s1_rdata, s1_mtime, s1_cmp, s1_disp, s2_mtime;

    task automatic do_req(input logic we, input logic [11:0] addr,
                          input logic [63:0] wdata, input logic [7:0] mask);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_wmask  = mask;
        resp_ready = 1'b1;
        s0_ready   = req_ready;
        s0_mtime   = misc_info.misc_mtime;
        @(negedge clk);
        s1_valid = resp_valid;
        s1_rdata = resp_rdata;
        s1_dwe   = display_we;
        s1_mtip  = mtip;
        s1_mtime = misc_info.misc_mtime;
        s1_cmp   = misc_info.misc_mtimecmp;
        s1_disp  = misc_info.misc_display;
        req_valid = 1'b0;
        @(negedge clk);
        s2_ready = req_ready;
        s2_valid = resp_valid;
        s2_dwe   = display_we;
        s2_mtip  = mtip;
        s2_mtime = misc_info.misc_mtime;
        $display("txn we=%0d addr=%h wdata=%h mask=%h rdata=%h", we, addr, wdata, mask, s1_rdata);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_rdata"}, resp_rdata, 64'd0);
        chk({tag, "_mtime"}, misc_info.misc_mtime, 64'd0);
        chk({tag, "_mtimecmp"}, misc_info.misc_mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
        chk({tag, "_display"}, misc_info.misc_display, 64'd0);
        chk({tag, "_mtip"}, 64'(mtip), 64'd0);
        chk({tag, "_display_we"}, 64'(display_we), 64'd0);
    endtask

    // Asserts reset for two cycles, checks reset state, releases on a falling edge.
    task automatic apply_reset(input string tag);
        rstn       = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_values(tag);
        rstn = 1'b1;
    endtask

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [63:0] wdata;
        logic [7:0]  mask;
        logic [63:0] exp_rdata;
        logic [63:0] exp_disp;
        logic [63:0] exp_cmp;
        logic        exp_dwe;
    } vec_t;

    vec_t vecs[9];

    initial begin
        passed    = 0;
        total     = 0;
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        resp_ready = 1'b1;

        vecs[0] = '{1'b1, 12'h010, 64'h0000_0000_DEAD_BEEF, 8'hFF, 64'd0,
                    64'h0000_0000_DEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[1] = '{1'b0, 12'h010, 64'd0, 8'h00, 64'h0000_0000_DEAD_BEEF,
                    64'h0000_0000_DEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[2] = '{1'b1, 12'h015, 64'h1111_2222_3333_4444, 8'h0F, 64'd0,
                    64'h0000_0000_3333_4444, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[3] = '{1'b1, 12'h010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'd0,
                    64'h0000_0000_3333_4444, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[4] = '{1'b0, 12'h040, 64'd0, 8'h00, 64'd0,
                    64'h0000_0000_3333_4444, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[5] = '{1'b1, 12'h040, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0,
                    64'h0000_0000_3333_4444, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[6] = '{1'b0, 12'h00B, 64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'h0000_0000_3333_4444, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[7] = '{1'b1, 12'h010, 64'hA5A5_A5A5_9999_9999, 8'hF0, 64'd0,
                    64'hA5A5_A5A5_3333_4444, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[8] = '{1'b0, 12'h017, 64'd0, 8'hFF, 64'hA5A5_A5A5_3333_4444,
                    64'hA5A5_A5A5_3333_4444, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

        // Reset state, then free-running count with no requests.
        apply_reset("rst0");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("count_mtime%0d", i), misc_info.misc_mtime, 64'(i));
            chk($sformatf("count_mtip%0d", i), 64'(mtip), 64'd0);
            @(negedge clk);
        end

        for (int i = 0; i < 9; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mask);
            chk($sformatf("v%0d_ready0", i), 64'(s0_ready), 64'd1);
            chk($sformatf("v%0d_resp_valid", i), 64'(s1_valid), 64'd1);
            chk($sformatf("v%0d_rdata", i), s1_rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_display", i), s1_disp, vecs[i].exp_disp);
            chk($sformatf("v%0d_mtimecmp", i), s1_cmp, vecs[i].exp_cmp);
            chk($sformatf("v%0d_dwe", i), 64'(s1_dwe), 64'(vecs[i].exp_dwe));
            chk($sformatf("v%0d_ready2", i), 64'(s2_ready), 64'd1);
            chk($sformatf("v%0d_valid2", i), 64'(s2_valid), 64'd0);
            chk($sformatf("v%0d_dwe2", i), 64'(s2_dwe), 64'd0);
        end

        // mtip rise: mtimecmp=0x10 written right after reset release.
        apply_reset("rst1");
        do_req(1'b1, 12'h008, 64'h10, 8'hFF);
        chk("cmp_written", s1_cmp, 64'h10);
        begin
            int waited;
            waited = 0;
            while (misc_info.misc_mtime != 64'h10 && waited < 64) begin
                @(negedge clk);
                waited++;
            end
            chk("mtime_reach_10", misc_info.misc_mtime, 64'h10);
        end
        chk("mtip_at_10", 64'(mtip), 64'd0);
        @(negedge clk);
        chk("mtip_rise", 64'(mtip), 64'd1);

        // mtip fall after raising mtimecmp.
        do_req(1'b1, 12'h008, 64'h1000, 8'hFF);
        chk("cmp_raised", s1_cmp, 64'h1000);
        chk("mtip_fall_n1", 64'(s1_mtip), 64'd1);
        chk("mtip_fall_n2", 64'(s2_mtip), 64'd0);

        // Upper-word mtime write colliding with a tick: no increment that cycle.
        do_req(1'b1, 12'h000, 64'h1234_5678_0000_0000, 8'hF0);
        chk("mtime_merge", s1_mtime, {32'h1234_5678, s0_mtime[31:0]});
        chk("mtime_resume", s2_mtime, {32'h1234_5678, s0_mtime[31:0]} + 64'd1);

        // mtime wrap.
        do_req(1'b1, 12'h000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        chk("mtime_max", s1_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("mtime_wrap", s2_mtime, 64'd0);

        // Stalled response with ignored requests, then reset mid-RESP.
        do_req(1'b1, 12'h010, 64'h0000_0000_DEAD_BEEF, 8'hFF);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 12'h010;
        resp_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d_valid", i), 64'(resp_valid), 64'd1);
            chk($sformatf("stall%0d_rdata", i), resp_rdata, 64'h0000_0000_DEAD_BEEF);
            chk($sformatf("stall%0d_ready", i), 64'(req_ready), 64'd0);
            req_we    = 1'b1;
            req_wdata = 64'h0BAD_0BAD_0BAD_0BAD;
            req_wmask = 8'hFF;
            @(negedge clk);
        end
        chk("stall_display", misc_info.misc_display, 64'h0000_0000_DEAD_BEEF);
        chk("stall_dwe", 64'(display_we), 64'd0);
        $display("txn stalled read of display held for 5 cycles");
        #2 rstn = 1'b0;
        #1 check_reset_values("async_rst");
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d_valid", i), 64'(resp_valid), 64'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
